// File: rtl/i2c_recv.sv
// i2c_recv: write-only I2C target; ACKs DEV_ADDR and two data bytes, then
// presents the 16-bit word with a one-cycle valid pulse.
module i2c_recv #(
    parameter logic [6:0] DEV_ADDR = 7'h1A
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_scl,
    inout  wire         io_sda,
    output logic [15:0] o_data,
    output logic        o_valid,
    output logic        o_busy,
    output logic        o_err
);
    typedef enum logic [2:0] {IDLE, ADDR, ACK_A, BYTE_H, ACK_H, BYTE_L, ACK_L, WAIT_STOP} state_t;
    state_t state, state_n;
    logic [2:0] scl_sh, sda_sh;
    logic scl_rise, scl_fall, sda_rise, sda_fall, start, stop;
    logic drive, drive_n, busy_n, valid_n, err_n, hold_ld, data_ld, clr_bits, collect;
    logic [7:0] shift, hold;
    logic [2:0] cnt;
    logic done;
    assign io_sda = drive ? 1'b0 : 1'bz;
    // [0],[1] are the sync flops, [2] is the history flop
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            scl_sh <= 3'b111;
            sda_sh <= 3'b111;
        end else begin
            scl_sh <= {scl_sh[1:0], i_scl};
            sda_sh <= {sda_sh[1:0], io_sda};
        end
    end
    assign scl_rise = scl_sh[1] & ~scl_sh[2];
    assign scl_fall = ~scl_sh[1] & scl_sh[2];
    assign sda_rise = sda_sh[1] & ~sda_sh[2];
    assign sda_fall = ~sda_sh[1] & sda_sh[2];
    assign start = sda_fall & scl_sh[1];
    assign stop = sda_rise & scl_sh[1];
    assign collect = (state == ADDR) || (state == BYTE_H) || (state == BYTE_L);
    always_comb begin
        state_n = state;
        drive_n = drive;
        busy_n = o_busy;
        valid_n = 1'b0;
        err_n = 1'b0;
        hold_ld = 1'b0;
        data_ld = 1'b0;
        clr_bits = 1'b0;
        if (state != IDLE && (start || stop)) begin
            state_n = start ? ADDR : IDLE;
            drive_n = 1'b0;
            busy_n = 1'b0;
            clr_bits = 1'b1;
            err_n = o_busy && (state == BYTE_H || state == ACK_H || state == BYTE_L);
        end else begin
            case (state)
                IDLE: begin
                    state_n = start ? ADDR : IDLE;
                    clr_bits = start;
                end
                ADDR: if (scl_fall && done) begin
                    clr_bits = 1'b1;
                    drive_n = (shift == {DEV_ADDR, 1'b0});
                    busy_n = drive_n;
                    state_n = drive_n ? ACK_A : WAIT_STOP;
                end
                ACK_A: if (scl_fall) begin
                    drive_n = 1'b0;
                    clr_bits = 1'b1;
                    state_n = BYTE_H;
                end
                BYTE_H: if (scl_fall && done) begin
                    hold_ld = 1'b1;
                    drive_n = 1'b1;
                    clr_bits = 1'b1;
                    state_n = ACK_H;
                end
                ACK_H: if (scl_fall) begin
                    drive_n = 1'b0;
                    clr_bits = 1'b1;
                    state_n = BYTE_L;
                end
                BYTE_L: if (scl_fall && done) begin
                    data_ld = 1'b1;
                    valid_n = 1'b1;
                    drive_n = 1'b1;
                    clr_bits = 1'b1;
                    state_n = ACK_L;
                end
                ACK_L: if (scl_fall) begin
                    drive_n = 1'b0;
                    state_n = WAIT_STOP;
                end
                default: drive_n = 1'b0;
            endcase
        end
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= IDLE;
            drive <= 1'b0;
            o_busy <= 1'b0;
            o_valid <= 1'b0;
            o_err <= 1'b0;
        end else begin
            state <= state_n;
            drive <= drive_n;
            o_busy <= busy_n;
            o_valid <= valid_n;
            o_err <= err_n;
        end
    end
    // done marks the 8th bit sampled; the byte is acted on at the following SCL fall
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            shift <= 8'h00;
            cnt <= 3'd7;
            done <= 1'b0;
        end else if (clr_bits) begin
            cnt <= 3'd7;
            done <= 1'b0;
        end else if (collect && scl_rise && !done) begin
            shift <= {shift[6:0], sda_sh[1]};
            cnt <= cnt - 3'd1;
            done <= (cnt == 3'd0);
        end
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            hold <= 8'h00;
            o_data <= 16'h0000;
        end else begin
            if (hold_ld) hold <= shift;
            if (data_ld) o_data <= {hold, shift};
        end
    end
endmodule

// File: tb/tb_i2c_recv.sv
// tb_i2c_recv: directed I2C master transactions against i2c_recv with hand-computed expectations.
module tb_i2c_recv;
    localparam int Q = 8;
    logic clk, i_rst_n, m_scl, m_sda_low;
    logic [15:0] o_data;
    logic o_valid, o_busy, o_err;
    wire sda;
    int n_cmp = 0, n_bad = 0;
    int v_cnt = 0, e_cnt = 0, both_cnt = 0, dut_low = 0;
    int v0, e0, l0;
    logic ack;
    logic [3:0] vp;
    pullup (sda);
    assign sda = m_sda_low ? 1'b0 : 1'bz;
    i2c_recv #(.DEV_ADDR(7'h1A)) dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_scl(m_scl), .io_sda(sda),
        .o_data(o_data), .o_valid(o_valid), .o_busy(o_busy), .o_err(o_err)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (o_valid) v_cnt <= v_cnt + 1;
        if (o_err) e_cnt <= e_cnt + 1;
        if (o_valid && o_err) both_cnt <= both_cnt + 1;
        if (sda === 1'b0 && !m_sda_low) dut_low <= dut_low + 1;
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic set_bit(input logic b);
        tick(Q / 2);
        m_sda_low = !b;
        tick(Q / 2);
        m_scl = 1'b1;
        tick(Q);
        m_scl = 1'b0;
    endtask
    task automatic send_start;
        tick(Q / 2);
        m_sda_low = 1'b0;
        tick(Q / 2);
        m_scl = 1'b1;
        tick(Q);
        m_sda_low = 1'b1;
        tick(Q);
        m_scl = 1'b0;
    endtask
    task automatic send_stop;
        tick(Q / 2);
        m_sda_low = 1'b1;
        tick(Q / 2);
        m_scl = 1'b1;
        tick(Q);
        m_sda_low = 1'b0;
        tick(Q);
    endtask
    task automatic send_byte(input logic [7:0] b, output logic a, output logic [3:0] p);
        for (int i = 7; i >= 0; i--) set_bit(b[i]);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            p[i] = o_valid;
        end
        m_sda_low = 1'b0;
        tick(Q / 2);
        m_scl = 1'b1;
        tick(Q / 2);
        a = (sda === 1'b0);
        tick(Q / 2);
        m_scl = 1'b0;
    endtask
    initial begin
        i_rst_n = 1'b0;
        m_scl = 1'b1;
        m_sda_low = 1'b0;
        tick(3);
        i_rst_n = 1'b1;
        tick(2);
        check("rst_data", 32'(o_data), 32'h0);
        check("rst_valid", 32'(o_valid), 32'h0);
        check("rst_busy", 32'(o_busy), 32'h0);
        check("rst_err", 32'(o_err), 32'h0);
        check("rst_sda", 32'(sda), 32'h1);
        // full word 0x1E05
        v0 = v_cnt; e0 = e_cnt;
        send_start;
        send_byte(8'h34, ack, vp); check("t1_ack_a", 32'(ack), 32'h1);
        check("t1_busy", 32'(o_busy), 32'h1);
        send_byte(8'h1E, ack, vp); check("t1_ack_h", 32'(ack), 32'h1);
        send_byte(8'h05, ack, vp); check("t1_ack_l", 32'(ack), 32'h1);
        check("t1_vtime", 32'(vp), 32'h4);
        check("t1_data", 32'(o_data), 32'h1E05);
        send_stop;
        check("t1_busy_stop", 32'(o_busy), 32'h0);
        check("t1_vcnt", 32'(v_cnt - v0), 32'h1);
        check("t1_ecnt", 32'(e_cnt - e0), 32'h0);
        // wrong address, then read request
        v0 = v_cnt; l0 = dut_low;
        send_start;
        send_byte(8'h36, ack, vp); check("t2_ack_1b", 32'(ack), 32'h0);
        check("t2_busy_1b", 32'(o_busy), 32'h0);
        send_stop;
        send_start;
        send_byte(8'h35, ack, vp); check("t2_ack_rd", 32'(ack), 32'h0);
        check("t2_busy_rd", 32'(o_busy), 32'h0);
        send_stop;
        check("t2_sda_low", 32'(dut_low - l0), 32'h0);
        check("t2_vcnt", 32'(v_cnt - v0), 32'h0);
        check("t2_data", 32'(o_data), 32'h1E05);
        // truncated by STOP after one byte
        v0 = v_cnt; e0 = e_cnt;
        send_start;
        send_byte(8'h34, ack, vp); check("t3_ack_a", 32'(ack), 32'h1);
        send_byte(8'hAB, ack, vp); check("t3_ack_h", 32'(ack), 32'h1);
        send_stop;
        check("t3_ecnt", 32'(e_cnt - e0), 32'h1);
        check("t3_vcnt", 32'(v_cnt - v0), 32'h0);
        check("t3_data", 32'(o_data), 32'h1E05);
        check("t3_busy", 32'(o_busy), 32'h0);
        // truncated by repeated START, then a full word
        v0 = v_cnt; e0 = e_cnt;
        send_start;
        send_byte(8'h34, ack, vp);
        send_byte(8'h12, ack, vp);
        send_start;
        check("t4_ecnt_rs", 32'(e_cnt - e0), 32'h1);
        send_byte(8'h34, ack, vp); check("t4_ack_a", 32'(ack), 32'h1);
        send_byte(8'h34, ack, vp);
        send_byte(8'h56, ack, vp); check("t4_ack_l", 32'(ack), 32'h1);
        check("t4_vtime", 32'(vp), 32'h4);
        send_stop;
        check("t4_data", 32'(o_data), 32'h3456);
        check("t4_vcnt", 32'(v_cnt - v0), 32'h1);
        check("t4_ecnt", 32'(e_cnt - e0), 32'h1);
        // third byte is NACKed
        v0 = v_cnt; e0 = e_cnt;
        send_start;
        send_byte(8'h34, ack, vp);
        send_byte(8'h12, ack, vp);
        send_byte(8'h34, ack, vp);
        send_byte(8'hFF, ack, vp); check("t5_nack3", 32'(ack), 32'h0);
        check("t5_busy", 32'(o_busy), 32'h1);
        send_stop;
        check("t5_data", 32'(o_data), 32'h1234);
        check("t5_vcnt", 32'(v_cnt - v0), 32'h1);
        check("t5_ecnt", 32'(e_cnt - e0), 32'h0);
        // reset while the ACK_H drive-low is active
        send_start;
        send_byte(8'h34, ack, vp);
        for (int i = 7; i >= 0; i--) set_bit(1'(8'h99 >> i));
        m_sda_low = 1'b0;
        tick(4);
        check("t6_ackh_drive", 32'(sda), 32'h0);
        i_rst_n = 1'b0;
        tick(1);
        i_rst_n = 1'b1;
        check("t6_sda_rel", 32'(sda), 32'h1);
        check("t6_data", 32'(o_data), 32'h0);
        check("t6_busy", 32'(o_busy), 32'h0);
        check("t6_valid", 32'(o_valid), 32'h0);
        check("t6_err", 32'(o_err), 32'h0);
        m_scl = 1'b1;
        tick(Q);
        m_scl = 1'b0;
        send_stop;
        v0 = v_cnt;
        send_start;
        send_byte(8'h34, ack, vp); check("t6_ack_a", 32'(ack), 32'h1);
        send_byte(8'h00, ack, vp); check("t6_ack_h", 32'(ack), 32'h1);
        send_byte(8'h7F, ack, vp); check("t6_ack_l", 32'(ack), 32'h1);
        check("t6_vtime", 32'(vp), 32'h4);
        send_stop;
        check("t6_word", 32'(o_data), 32'h007F);
        check("t6_vcnt", 32'(v_cnt - v0), 32'h1);
        check("valid_err_overlap", 32'(both_cnt), 32'h0);
        check("total_err", 32'(e_cnt), 32'h2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
